f1_reaction_timer: RTL and testbench
====================================

Name: f1_reaction_timer

Overview:
- Consumer end of the F1 start-light interface: watches the light vector produced by the light-sequence driver and the driver's button.
- Times the interval from lights-out to the button press in tick units, usually 1 ms ticks from a clktick instance.
- Flags a jump start when the button is pressed before lights-out.
- Sits beside the light-sequence block at top level; its result feeds the 7-segment/hex display path.

Parameters:
- WIDTH, 8, width of the light vector; all-on is every bit = 1.
- CNT_W, 16, width of the reaction counter and result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- lights  input  WIDTH  light vector from the sequence driver, synchronous to clk.
- trigger  input  1  driver button level, already synchronised and debounced, synchronous to clk.
- tick  input  1  single-cycle timebase pulse.
- time_out  output  CNT_W  last reaction time in ticks.
- valid  output  1  time_out holds a fresh result.
- jump_start  output  1  last attempt was a jump start.
- busy  output  1  high while timing.

Behaviour:
- Reset (rst = 0, async):
  - state = IDLE; time_out = 0; count = 0; valid = 0; jump_start = 0; busy = 0; trig_prev = 0.
- Trigger edge:
  - press = trigger & ~trig_prev, combinational.
  - trig_prev is registered every cycle.
  - A held button yields exactly one press.
- IDLE:
  - lights != 0 -> ARMED; on this transition clear valid and jump_start.
  - press is ignored.
- ARMED (sequence building):
  - press -> FAULT (has priority).
  - else lights == all-ones -> FULL.
  - else lights == 0 -> IDLE (aborted sequence, no flags).
- FULL (all lights on, waiting for lights-out):
  - press -> FAULT; this also applies in the same cycle that lights becomes 0.
  - else lights == 0 -> TIMING, count <= 0.
  - Any other nonzero pattern: stay.
- TIMING:
  - busy = 1.
  - tick increments count, saturating at 2^CNT_W-1 (no wrap).
  - press -> DONE, time_out <= count, valid <= 1.
    - If tick coincides with press, the tick is included: time_out = sat(count+1).
  - lights != 0 before any press -> ARMED; valid and jump_start are cleared, time_out is unchanged (missed attempt).
- DONE:
  - valid, time_out held.
  - press ignored.
  - lights != 0 -> ARMED; clears valid.
- FAULT:
  - jump_start <= 1 on entry; time_out <= 0; valid stays 0.
  - lights == 0 -> IDLE; jump_start stays set until the next IDLE->ARMED.
- Latency: valid/time_out/jump_start change on the clock edge after the cycle in which press is seen.
- State encoding: 3-bit, implementation's choice; FSM in a single always_ff plus combinational next-state logic.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Reset: hold rst = 0 with lights = 8'hFF, trigger = 1 -> all outputs 0; release -> state IDLE, no press detected until trigger falls and rises again.
- Normal run:
  - lights 01, 03, … FF, then 00; tick every 4 cycles; press after 12 ticks -> valid = 1, time_out = 12, jump_start = 0 one cycle after press.
  - Holding trigger high 50 cycles -> time_out stays 12.
- Jump start:
  - Press while lights = 8'h07 -> jump_start = 1, valid = 0, time_out = 0.
  - Lights to 00 then 01 -> jump_start clears on the 01 cycle.
- Coincidences:
  - Press in the same cycle lights FF->00 -> FAULT, jump_start = 1.
  - Press in the same cycle as tick with count = 5 -> time_out = 6.
- Saturation: CNT_W = 4, tick every cycle, press after 40 cycles of TIMING -> time_out = 15.
- Re-arm and abort:
  - After a valid result, lights = 01 -> valid = 0 next cycle.
  - Lights 01 -> 00 without reaching FF -> back to IDLE, no flags.
  - Async reset asserted during TIMING -> busy = 0 immediately.

Source files
------------

// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: measures ticks from lights-out to the button press
// and flags presses that arrive before lights-out as jump starts.
module f1_reaction_timer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lights,
  input  logic             trigger,
  input  logic             tick,
  output logic [CNT_W-1:0] time_out,
  output logic             valid,
  output logic             jump_start,
  output logic             busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_FULL   = 3'd2;
  localparam logic [2:0] S_TIMING = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state, nxt;
  logic             trig_prev;
  logic [CNT_W-1:0] count;
  logic             press, all_on, dark;
  logic [CNT_W-1:0] cnt_nxt;

  assign press  = trigger & ~trig_prev;
  assign all_on = &lights;
  assign dark   = (lights == '0);
  assign busy   = (state == S_TIMING);
  // Saturating tick count; also the value captured when press and tick coincide.
  assign cnt_nxt = (tick && count != CNT_MAX) ? count + 1'b1 : count;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (!dark) nxt = S_ARMED;
      S_ARMED:  if (press) nxt = S_FAULT;
                else if (all_on) nxt = S_FULL;
                else if (dark) nxt = S_IDLE;
      S_FULL:   if (press) nxt = S_FAULT;
                else if (dark) nxt = S_TIMING;
      S_TIMING: if (press) nxt = S_DONE;
                else if (!dark) nxt = S_ARMED;
      S_DONE:   if (!dark) nxt = S_ARMED;
      S_FAULT:  if (dark) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      trig_prev  <= 1'b0;
      count      <= '0;
      time_out   <= '0;
      valid      <= 1'b0;
      jump_start <= 1'b0;
    end else begin
      state     <= nxt;
      trig_prev <= trigger;
      case (state)
        S_IDLE: if (!dark) begin
          valid      <= 1'b0;
          jump_start <= 1'b0;
        end
        S_ARMED, S_FULL: begin
          if (press) begin
            jump_start <= 1'b1;
            time_out   <= '0;
            valid      <= 1'b0;
          end else if (state == S_FULL && dark) begin
            count <= '0;
          end
        end
        S_TIMING: begin
          if (press) begin
            time_out <= cnt_nxt;
            valid    <= 1'b1;
          end else if (!dark) begin
            // Lights came back before a press: attempt missed, previous time kept.
            valid      <= 1'b0;
            jump_start <= 1'b0;
          end else begin
            count <= cnt_nxt;
          end
        end
        S_DONE: if (!dark) valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer: a behavioural model checked every cycle
// against a 16-bit and a 4-bit counter instance, plus literal spot checks.
module tb_f1_reaction_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lights;
  logic        trigger, tick;
  logic [15:0] to16;
  logic [3:0]  to4;
  logic        v16, j16, b16, v4, j4, b4;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  f1_reaction_timer #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .lights(lights), .trigger(trigger), .tick(tick),
    .time_out(to16), .valid(v16), .jump_start(j16), .busy(b16));

  f1_reaction_timer #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .lights(lights), .trigger(trigger), .tick(tick),
    .time_out(to4), .valid(v4), .jump_start(j4), .busy(b4));

  always #5 clk = ~clk;

  // Model phases: idle, building, all lit, timing, result, jump start.
  localparam int P_IDLE = 0, P_BUILD = 1, P_FULL = 2, P_TIME = 3, P_DONE = 4, P_FAULT = 5;
  int m_ph = P_IDLE, m_cnt = 0, m_time = 0;
  bit m_valid = 0, m_jump = 0, m_tp = 0;

  function automatic int sat(int v, int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Count is kept unbounded; the width limit is applied only when comparing.
  always @(posedge clk or negedge rst) begin
    bit press;
    if (!rst) begin
      m_ph = P_IDLE; m_cnt = 0; m_time = 0; m_valid = 0; m_jump = 0; m_tp = 0;
    end else begin
      press = trigger && !m_tp;
      m_tp  = trigger;
      case (m_ph)
        P_IDLE:  if (lights != 0) begin m_ph = P_BUILD; m_valid = 0; m_jump = 0; end
        P_BUILD, P_FULL: begin
          if (press) begin m_ph = P_FAULT; m_jump = 1; m_time = 0; m_valid = 0; end
          else if (m_ph == P_BUILD && lights == 8'hFF) m_ph = P_FULL;
          else if (lights == 0) begin
            if (m_ph == P_FULL) begin m_ph = P_TIME; m_cnt = 0; end
            else m_ph = P_IDLE;
          end
        end
        P_TIME: begin
          if (press) begin m_time = m_cnt + int'(tick); m_valid = 1; m_ph = P_DONE; end
          else if (lights != 0) begin m_ph = P_BUILD; m_valid = 0; m_jump = 0; end
          else m_cnt = m_cnt + int'(tick);
        end
        P_DONE:  if (lights != 0) begin m_ph = P_BUILD; m_valid = 0; end
        P_FAULT: if (lights == 0) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (cmp_en) begin
    chk("time_out16", 32'(to16), 32'(sat(m_time, 16)));
    chk("valid16",    32'(v16),  32'(m_valid));
    chk("jump16",     32'(j16),  32'(m_jump));
    chk("busy16",     32'(b16),  32'(m_ph == P_TIME));
    chk("time_out4",  32'(to4),  32'(sat(m_time, 4)));
    chk("valid4",     32'(v4),   32'(m_valid));
    chk("jump4",      32'(j4),   32'(m_jump));
    chk("busy4",      32'(b4),   32'(m_ph == P_TIME));
  end

  // Apply one cycle of inputs (called at a negedge), return at the next negedge.
  task automatic cyc(input logic [7:0] l, input logic tr, input logic tk);
    lights = l; trigger = tr; tick = tk;
    @(negedge clk);
  endtask

  task automatic build_to_full();
    logic [7:0] l = 8'h01;
    for (int i = 0; i < 8; i++) begin
      cyc(l, 1'b0, 1'b0);
      l = (l << 1) | 8'h01;
    end
  endtask

  initial begin
    rst = 1'b1; lights = 8'hFF; trigger = 1'b1; tick = 1'b0;
    #1 rst = 1'b0;
    cmp_en = 1;
    @(negedge clk);
    chk("lit_rst_time", 32'(to16), 0);
    chk("lit_rst_valid", 32'(v16), 0);
    chk("lit_rst_jump", 32'(j16), 0);
    chk("lit_rst_busy", 32'(b16), 0);
    @(negedge clk);
    rst = 1'b1;
    // Trigger held through reset release must not count as a press.
    cyc(8'hFF, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk("lit_held_nojump", 32'(j16), 0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("lit_held_busy", 32'(b16), 1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h01, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);

    // Normal run: 12 ticks, one every 4 cycles.
    build_to_full();
    cyc(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 48; k++) cyc(8'h00, 1'b0, (k % 4) == 3);
    cyc(8'h00, 1'b1, 1'b0);
    chk("lit_normal_time", 32'(to16), 12);
    chk("lit_normal_valid", 32'(v16), 1);
    chk("lit_normal_jump", 32'(j16), 0);
    for (int k = 0; k < 50; k++) cyc(8'h00, 1'b1, (k % 4) == 3);
    chk("lit_hold_time", 32'(to16), 12);
    cyc(8'h00, 1'b0, 1'b0);

    // Re-arm clears valid; then a jump start at 07.
    cyc(8'h01, 1'b0, 1'b0);
    chk("lit_rearm_valid", 32'(v16), 0);
    cyc(8'h03, 1'b0, 1'b0);
    cyc(8'h07, 1'b1, 1'b0);
    chk("lit_js_jump", 32'(j16), 1);
    chk("lit_js_valid", 32'(v16), 0);
    chk("lit_js_time", 32'(to16), 0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("lit_js_hold", 32'(j16), 1);
    cyc(8'h01, 1'b0, 1'b0);
    chk("lit_js_clear", 32'(j16), 0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("lit_abort_valid", 32'(v16), 0);

    // Press coincident with lights-out is still a jump start.
    build_to_full();
    cyc(8'h00, 1'b1, 1'b0);
    chk("lit_coin_jump", 32'(j16), 1);
    cyc(8'h00, 1'b0, 1'b0);

    // Press coincident with a tick at count 5 includes the tick.
    build_to_full();
    cyc(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    chk("lit_tickpress_time", 32'(to16), 6);
    cyc(8'h00, 1'b0, 1'b0);

    // Saturation: 40 ticks, 4-bit instance pins at 15.
    build_to_full();
    cyc(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("lit_sat_time4", 32'(to4), 15);
    chk("lit_sat_time16", 32'(to16), 40);
    cyc(8'h00, 1'b0, 1'b0);

    // Missed attempt: lights return during timing, time_out kept.
    build_to_full();
    cyc(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h01, 1'b0, 1'b0);
    chk("lit_miss_time", 32'(to16), 40);
    chk("lit_miss_busy", 32'(b16), 0);
    cyc(8'h00, 1'b0, 1'b0);

    // Async reset during timing.
    build_to_full();
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    chk("lit_pre_rst_busy", 32'(b16), 1);
    #2 rst = 1'b0;
    #1 chk("lit_async_busy", 32'(b16), 0);
    chk("lit_async_time", 32'(to16), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
